// File: rtl/softmax_out_serializer.sv
// Buffers whole Q8.8 probability vectors and streams them one element per beat.
// Optional argmax tracking is compiled in with SOFTMAX_ARGMAX_EN.
module softmax_out_serializer #(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic [N*16-1:0]      prob_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 overflow,
  output logic                 argmax_valid,
  output logic [$clog2(N)-1:0] argmax_idx,
  output logic [15:0]          argmax_val
);

  localparam int IW = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_ELEM = IW'(N - 1);

  logic [15:0]   mem [DEPTH][N];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] elem;

  logic xfer, last_xfer, push;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr][elem] : '0;
  assign out_idx   = elem;
  assign out_last  = (elem == LAST_ELEM);

  assign xfer      = out_valid & out_ready & en;
  assign last_xfer = xfer & out_last;
  // A full buffer still accepts when its head slot frees up on this same edge.
  assign push      = valid_in & en & ((count < FULL) | last_xfer);

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[wr_ptr][i] <= prob_flat[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      elem     <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      if (valid_in && !push) overflow <= 1'b1;
      if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
      if (xfer) elem <= last_xfer ? '0 : elem + IW'(1);
      if (last_xfer) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
      if (push && !last_xfer)      count <= count + CW'(1);
      else if (!push && last_xfer) count <= count - CW'(1);
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  logic [15:0]   run_max, nxt_max;
  logic [IW-1:0] run_idx, nxt_idx;

  // Element 0 seeds the running max; strict compare keeps the lower index on ties.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    if ((elem == '0) || (out_data > run_max)) begin
      nxt_max = out_data;
      nxt_idx = elem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max      <= '0;
      run_idx      <= '0;
      argmax_valid <= 1'b0;
      argmax_idx   <= '0;
      argmax_val   <= '0;
    end else if (en) begin
      argmax_valid <= last_xfer;
      if (xfer) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
      end
      if (last_xfer) begin
        argmax_val <= nxt_max;
        argmax_idx <= nxt_idx;
      end
    end
  end
`else
  assign argmax_valid = 1'b0;
  assign argmax_idx   = '0;
  assign argmax_val   = '0;
`endif

endmodule
